// File: rtl/guess_solver.sv
// Automatic binary-search player for the number-guessing game.
// It drives guesses into the game datapath and reads back the compare flags.
//
// state | meaning
// IDLE  | waiting for i_start after reset
// GUESS | o_submit strobe; compare flags sampled, range narrowed
// CHECK | datapath counter settled; decide whether to stop or guess again
// DONE  | result held until the next i_start
module guess_solver #(
   parameter int W     = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic             i_over,
   input  logic             i_under,
   input  logic             i_equal,
   input  logic             i_out_of_guesses,
   output logic [W-1:0]     o_guess,
   output logic             o_submit,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_found,
   output logic             o_error,
   output logic [CNT_W-1:0] o_num_guesses
);

   typedef enum logic [1:0] {IDLE, GUESS, CHECK, DONE} state_t;

   state_t           state, state_n;
   logic [W-1:0]     lo, hi, lo_n, hi_n;
   logic             found, error, found_n, error_n;
   logic [CNT_W-1:0] count, count_n;
   logic [W:0]       sum;

   // Extra bit keeps the midpoint correct when lo + hi exceeds the W-bit range
   assign sum     = {1'b0, lo} + {1'b0, hi};
   assign o_guess = sum[W:1];

   assign o_submit      = (state == GUESS);
   assign o_busy        = (state == GUESS) || (state == CHECK);
   assign o_done        = (state == DONE);
   assign o_found       = (state == DONE) && found;
   assign o_error       = (state == DONE) && error;
   assign o_num_guesses = count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         lo    <= '0;
         hi    <= '1;
         found <= 1'b0;
         error <= 1'b0;
         count <= '0;
      end else begin
         state <= state_n;
         lo    <= lo_n;
         hi    <= hi_n;
         found <= found_n;
         error <= error_n;
         count <= count_n;
      end
   end

   always_comb begin
      state_n = state;
      lo_n    = lo;
      hi_n    = hi;
      found_n = found;
      error_n = error;
      count_n = count;
      case (state)
         IDLE, DONE: begin
            if (i_start) begin
               lo_n    = '0;
               hi_n    = '1;
               found_n = 1'b0;
               error_n = 1'b0;
               count_n = '0;
               state_n = i_out_of_guesses ? DONE : GUESS;
            end
         end
         GUESS: begin
            count_n = (count == '1) ? count : count + CNT_W'(1);
            state_n = CHECK;
            if ({i_over, i_under, i_equal} == 3'b001) begin
               lo_n    = o_guess;
               hi_n    = o_guess;
               found_n = 1'b1;
            end else if ({i_over, i_under, i_equal} == 3'b100) begin
               // Guess already at the low bound yet reported high: contradiction
               if (o_guess == lo) error_n = 1'b1;
               else               hi_n    = o_guess - W'(1);
            end else if ({i_over, i_under, i_equal} == 3'b010) begin
               if (o_guess == hi) error_n = 1'b1;
               else               lo_n    = o_guess + W'(1);
            end else begin
               error_n = 1'b1;
            end
         end
         CHECK: begin
            if (found || error || i_out_of_guesses) state_n = DONE;
            else                                    state_n = GUESS;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_guess_solver.sv
// Bench for guess_solver: a behavioural game datapath answers the guesses,
// and a queue of expected guesses is checked on every submit strobe.
module tb_guess_solver;

   localparam int W     = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             i_start;
   logic             i_over, i_under, i_equal, i_out_of_guesses;
   logic [W-1:0]     o_guess;
   logic             o_submit, o_busy, o_done, o_found, o_error;
   logic [CNT_W-1:0] o_num_guesses;

   int checks = 0;
   int errors = 0;
   int actual = 0;
   int left   = 7;
   bit force_bad = 1'b0;
   int exp_q[$];
   int cyc;

   guess_solver #(.W(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .i_start(i_start),
      .i_over(i_over), .i_under(i_under), .i_equal(i_equal),
      .i_out_of_guesses(i_out_of_guesses),
      .o_guess(o_guess), .o_submit(o_submit), .o_busy(o_busy),
      .o_done(o_done), .o_found(o_found), .o_error(o_error),
      .o_num_guesses(o_num_guesses)
   );

   always #5 clk = ~clk;

   // Game datapath model
   always_comb begin
      if (force_bad) begin
         i_over  = 1'b1;
         i_under = 1'b1;
         i_equal = 1'b0;
      end else begin
         i_over  = (int'(o_guess) > actual);
         i_under = (int'(o_guess) < actual);
         i_equal = (int'(o_guess) == actual);
      end
      i_out_of_guesses = (left == 0);
   end

   always @(posedge clk)
      if (!reset && o_submit && left > 0) left <= left - 1;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (o_submit === 1'b1) begin
         if (exp_q.size() == 0) check("unexpected_submit", int'(o_guess), -1);
         else                   check("guess_seq", int'(o_guess), exp_q.pop_front());
      end
   end

   task automatic start_pulse();
      @(negedge clk) i_start = 1'b1;
      @(negedge clk) i_start = 1'b0;
   endtask

   task automatic wait_done(output int c);
      c = 1;
      while (o_done !== 1'b1 && c < 200) begin
         @(negedge clk);
         c++;
      end
      if (o_done !== 1'b1) check("done_timeout", c, -1);
   endtask

   task automatic push(input int v[]);
      foreach (v[i]) exp_q.push_back(v[i]);
   endtask

   initial begin
      reset   = 1'b1;
      i_start = 1'b0;
      #1;
      check("rst_guess", o_guess, 127);
      check("rst_submit", o_submit, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_found", o_found, 0);
      check("rst_error", o_error, 0);
      check("rst_count", o_num_guesses, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // First guess hits
      actual = 127; left = 7;
      push('{127});
      start_pulse();
      check("busy_in_guess", o_busy, 1);
      wait_done(cyc);
      check("t127_cycles", cyc, 3);
      check("t127_found", o_found, 1);
      check("t127_count", o_num_guesses, 1);
      check("t127_error", o_error, 0);
      check("t127_q", exp_q.size(), 0);

      // Two guesses, upper half
      actual = 191; left = 7;
      push('{127, 191});
      start_pulse();
      wait_done(cyc);
      check("t191_cycles", cyc, 5);
      check("t191_found", o_found, 1);
      check("t191_guess", o_guess, 191);
      check("t191_count", o_num_guesses, 2);
      repeat (3) @(negedge clk);
      check("t191_hold_done", o_done, 1);
      check("t191_hold_guess", o_guess, 191);

      // Datapath runs out of guesses before reaching 0
      actual = 0; left = 7;
      push('{127, 63, 31, 15, 7, 3, 1});
      start_pulse();
      wait_done(cyc);
      check("t0_cycles", cyc, 15);
      check("t0_found", o_found, 0);
      check("t0_error", o_error, 0);
      check("t0_count", o_num_guesses, 7);
      check("t0_guess", o_guess, 0);
      check("t0_q", exp_q.size(), 0);

      // Contradictory flags on the first submit
      actual = 50; left = 7; force_bad = 1'b1;
      push('{127});
      start_pulse();
      wait_done(cyc);
      force_bad = 1'b0;
      check("bad_cycles", cyc, 3);
      check("bad_error", o_error, 1);
      check("bad_found", o_found, 0);
      check("bad_count", o_num_guesses, 1);

      // Worst case, unlimited guesses
      actual = 255; left = 1000;
      push('{127, 191, 223, 239, 247, 251, 253, 254, 255});
      start_pulse();
      wait_done(cyc);
      check("t255_cycles", cyc, 19);
      check("t255_found", o_found, 1);
      check("t255_count", o_num_guesses, 9);
      check("t255_guess", o_guess, 255);

      // Start with no guesses left: straight to DONE, no submit
      actual = 10; left = 0;
      start_pulse();
      wait_done(cyc);
      check("oog_cycles", cyc, 1);
      check("oog_found", o_found, 0);
      check("oog_count", o_num_guesses, 0);

      // Reset during the second CHECK
      actual = 191; left = 7;
      push('{127, 191});
      start_pulse();
      repeat (3) @(negedge clk);
      check("pre_rst_busy", o_busy, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_busy", o_busy, 0);
      check("mid_rst_done", o_done, 0);
      check("mid_rst_found", o_found, 0);
      check("mid_rst_guess", o_guess, 127);
      check("mid_rst_count", o_num_guesses, 0);
      @(negedge clk);
      check("rst_no_submit", o_submit, 0);
      check("mid_rst_q", exp_q.size(), 0);
      reset = 1'b0;

      // i_start while busy is ignored
      actual = 191; left = 7;
      push('{127, 191});
      start_pulse();
      i_start = 1'b1;
      repeat (2) @(negedge clk);
      i_start = 1'b0;
      wait_done(cyc);
      check("ign_cycles", cyc + 2, 5);
      check("ign_found", o_found, 1);
      check("ign_count", o_num_guesses, 2);
      check("ign_q", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
